// File: rtl/fpu_addsub_issue.sv
// Issue/collect wrapper around a fixed-latency, non-stallable add/sub pipeline.
// Operations are accepted against a credit count covering both in-flight and
// buffered results, so every pipeline result is guaranteed a FIFO slot.
module fpu_addsub_issue #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned LATENCY    = 5,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TAG_BITS   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_a,
    input  logic [WIDTH-1:0]                in_b,
    input  logic                            in_op,
    input  logic [TAG_BITS-1:0]             in_tag,
    output logic [WIDTH-1:0]                pipe_a,
    output logic [WIDTH-1:0]                pipe_b,
    output logic                            pipe_op,
    input  logic [WIDTH-1:0]                pipe_r,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_r,
    output logic [TAG_BITS-1:0]             out_tag,
    output logic [$clog2(FIFO_DEPTH):0]     occupancy
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic                accept;
    logic                pop;
    logic                push;

    logic [CntW-1:0]     occupancy_q;
    logic [LATENCY:0]    trk_valid_q;
    logic [TAG_BITS-1:0] trk_tag_q [LATENCY+1];

    logic [WIDTH-1:0]    mem_r_q   [FIFO_DEPTH];
    logic [TAG_BITS-1:0] mem_tag_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wptr_q;
    logic [PtrW-1:0]     rptr_q;
    logic [CntW-1:0]     fifo_cnt_q;

    // Handshake decode; credit depends only on registered count (and reset).
    always_comb begin
        in_ready  = !rst && (occupancy_q != CntW'(FIFO_DEPTH));
        accept    = in_valid && in_ready;
        out_valid = (fifo_cnt_q != '0);
        pop       = out_valid && out_ready;
        push      = trk_valid_q[LATENCY];
        out_r     = out_valid ? mem_r_q[rptr_q]   : '0;
        out_tag   = out_valid ? mem_tag_q[rptr_q] : '0;
        occupancy = occupancy_q;
    end

    // Credit counter: in-flight plus buffered operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy_q <= '0;
        end else if (accept && !pop) begin
            occupancy_q <= occupancy_q + CntW'(1);
        end else if (!accept && pop) begin
            occupancy_q <= occupancy_q - CntW'(1);
        end
    end

    // Operand registers feeding the pipeline; hold when nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_a  <= '0;
            pipe_b  <= '0;
            pipe_op <= 1'b0;
        end else if (accept) begin
            pipe_a  <= in_a;
            pipe_b  <= in_b;
            pipe_op <= in_op;
        end
    end

    // Valid/tag line shifting in lockstep with the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            trk_valid_q <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                trk_tag_q[k] <= '0;
            end
        end else begin
            trk_valid_q  <= {trk_valid_q[LATENCY-1:0], accept};
            trk_tag_q[0] <= in_tag;
            for (int k = 0; k < LATENCY; k++) begin
                trk_tag_q[k+1] <= trk_tag_q[k];
            end
        end
    end

    // FIFO storage; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r_q[wptr_q]   <= pipe_r;
            mem_tag_q[wptr_q] <= trk_tag_q[LATENCY];
        end
    end

    // FIFO pointers and count; full/empty come from the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PtrW'(1);
            if (pop)  rptr_q <= rptr_q + PtrW'(1);
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + CntW'(1);
            end else if (!push && pop) begin
                fifo_cnt_q <= fifo_cnt_q - CntW'(1);
            end
        end
    end

    // Credit reserves a slot at accept time, so a capture into a full FIFO is a bug.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && fifo_cnt_q == CntW'(FIFO_DEPTH)));
        end
    end

endmodule

// File: tb/tb_fpu_addsub_issue.sv
// Scoreboard bench for fpu_addsub_issue. A stand-in fixed-latency pipeline
// (integer add/sub) sits behind the issue stage; the reference model tracks
// accepted operations in a queue with the cycle each result becomes visible.
module tb_fpu_addsub_issue;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned LATENCY    = 5;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned TAG_BITS   = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_a = '0;
    logic [WIDTH-1:0]      in_b = '0;
    logic                  in_op = 1'b0;
    logic [TAG_BITS-1:0]   in_tag = '0;
    logic [WIDTH-1:0]      pipe_a;
    logic [WIDTH-1:0]      pipe_b;
    logic                  pipe_op;
    logic [WIDTH-1:0]      pipe_r;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [WIDTH-1:0]      out_r;
    logic [TAG_BITS-1:0]   out_tag;
    logic [$clog2(FIFO_DEPTH):0] occupancy;

    fpu_addsub_issue #(
        .WIDTH(WIDTH), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .TAG_BITS(TAG_BITS)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_op(pipe_op), .pipe_r(pipe_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_tag(out_tag), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Stand-in pipeline: LATENCY register stages, never stalls.
    logic [WIDTH-1:0] pl [LATENCY];
    always @(posedge clk) begin
        pl[0] <= pipe_op ? (pipe_a - pipe_b) : (pipe_a + pipe_b);
        for (int k = 1; k < LATENCY; k++) pl[k] <= pl[k-1];
    end
    assign pipe_r = pl[LATENCY-1];

    typedef struct {
        logic [WIDTH-1:0]    r;
        logic [TAG_BITS-1:0] tag;
        longint              due;
    } exp_t;

    exp_t   exp_q[$];
    longint cyc = 0;
    int     occ_m = 0;
    int     acc_cnt = 0;
    int     stall_cnt = 0;
    int     n_pass = 0;
    int     n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: compares at the falling edge, then books the coming edge's
    // accept/pop into the model.
    always @(negedge clk) begin
        bit exp_valid;
        bit acc;
        bit pp;
        if (rst) begin
            chk(in_ready == 1'b0, "in_ready_during_rst", 64'(in_ready), 64'(0));
            exp_q.delete();
            occ_m = 0;
        end else begin
            exp_valid = (exp_q.size() != 0) && (exp_q[0].due <= cyc);
            chk(occupancy == ($clog2(FIFO_DEPTH)+1)'(occ_m), "occupancy",
                64'(occupancy), 64'(occ_m));
            chk(in_ready == (occ_m != FIFO_DEPTH), "in_ready", 64'(in_ready),
                64'(occ_m != FIFO_DEPTH));
            chk(out_valid == exp_valid, "out_valid", 64'(out_valid), 64'(exp_valid));
            if (exp_valid && out_valid) begin
                chk(out_r == exp_q[0].r, "out_r", 64'(out_r), 64'(exp_q[0].r));
                chk(out_tag == exp_q[0].tag, "out_tag", 64'(out_tag), 64'(exp_q[0].tag));
            end
            acc = in_valid && in_ready;
            pp  = out_valid && out_ready;
            if (in_valid && !in_ready) stall_cnt++;
            if (pp) begin
                if (exp_q.size() == 0) chk(1'b0, "pop_with_empty_model", 64'(1), 64'(0));
                else void'(exp_q.pop_front());
            end
            if (acc) begin
                exp_t e;
                e.r   = in_op ? (in_a - in_b) : (in_a + in_b);
                e.tag = in_tag;
                e.due = cyc + LATENCY + 2;
                exp_q.push_back(e);
                acc_cnt++;
            end
            occ_m = occ_m + int'(acc) - int'(pp);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit op, input logic [TAG_BITS-1:0] tag);
        in_valid = v; in_a = a; in_b = b; in_op = op; in_tag = tag;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            cycle();
            n++;
        end
        chk(exp_q.size() == 0, "drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int seen_valid;
        rst = 1'b1;
        repeat (3) cycle();
        chk(pipe_a == '0, "rst_pipe_a", 64'(pipe_a), 64'(0));
        chk(pipe_b == '0, "rst_pipe_b", 64'(pipe_b), 64'(0));
        chk(pipe_op == 1'b0, "rst_pipe_op", 64'(pipe_op), 64'(0));
        chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'(0));
        chk(out_r == '0, "rst_out_r", 64'(out_r), 64'(0));
        chk(out_tag == '0, "rst_out_tag", 64'(out_tag), 64'(0));
        chk(occupancy == '0, "rst_occupancy", 64'(occupancy), 64'(0));
        rst = 1'b0;
        #1;
        chk(in_ready == 1'b1, "in_ready_after_rst", 64'(in_ready), 64'(1));

        // Single add.
        out_ready = 1'b1;
        drive(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 4'd3);
        cycle();
        drive(1'b0, '0, '0, 1'b0, '0);
        drain();

        // Sub then add back to back.
        drive(1'b1, 32'h40A00000, 32'h40400000, 1'b1, 4'd1);
        cycle();
        drive(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 4'd2);
        cycle();
        drain();

        // Backpressure: only FIFO_DEPTH requests are accepted.
        out_ready = 1'b0;
        acc_cnt   = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), TAG_BITS'(i));
            cycle();
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        chk(acc_cnt == FIFO_DEPTH, "bp_accepted", 64'(acc_cnt), 64'(FIFO_DEPTH));
        chk(occupancy == FIFO_DEPTH, "bp_occupancy", 64'(occupancy), 64'(FIFO_DEPTH));
        chk(in_ready == 1'b0, "bp_in_ready", 64'(in_ready), 64'(0));
        drain();

        // Full throughput with out_ready held high.
        acc_cnt   = 0;
        stall_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), TAG_BITS'(i % 16));
            cycle();
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        chk(stall_cnt == 0, "tp_stalls", 64'(stall_cnt), 64'(0));
        chk(acc_cnt == 20, "tp_accepted", 64'(acc_cnt), 64'(20));
        drain();

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                  TAG_BITS'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, $urandom, 1'b0, TAG_BITS'(i + 5));
            cycle();
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk(occupancy == '0, "midrst_occupancy", 64'(occupancy), 64'(0));
        chk(in_ready == 1'b1, "midrst_in_ready", 64'(in_ready), 64'(1));
        chk(pipe_a == '0, "midrst_pipe_a", 64'(pipe_a), 64'(0));
        seen_valid = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (out_valid) seen_valid++;
        end
        chk(seen_valid == 0, "midrst_out_valid", 64'(seen_valid), 64'(0));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
